// File: rtl/keymill_pkg.sv
// keymill_pkg: shared register map, status bits, FSM states and generator taps
package keymill_pkg;
  localparam logic [5:0] IDX_CTRL   = 6'h00;
  localparam logic [5:0] IDX_KEY0   = 6'h01;
  localparam logic [5:0] IDX_IV0    = 6'h05;
  localparam logic [5:0] IDX_STREAM = 6'h01;
  localparam logic [5:0] IDX_ID     = 6'h21;
  localparam int CTRL_START = 0;
  localparam int CTRL_SWRST = 1;
  localparam int ST_BUSY    = 31;
  localparam int ST_EMPTY   = 30;
  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN} state_t;
  localparam int Z_HI  = 127;
  localparam int Z_AND = 63;
  localparam int FA_T0 = 127;
  localparam int FA_T1 = 125;
  localparam int FA_T2 = 100;
  localparam int FA_T3 = 98;
  localparam int FA_N0 = 64;
  localparam int FA_N1 = 32;
  localparam int FB_T0 = 127;
  localparam int FB_T1 = 126;
  localparam int FB_T2 = 101;
  localparam int FB_T3 = 99;
  localparam int FB_N0 = 70;
  localparam int FB_N1 = 40;
endpackage

// File: rtl/keymill_apb_if.sv
// keymill_apb_if: APB bus bundle between an SoC master and keymill_apb
interface keymill_apb_if;
  logic [7:0]  vpsel;
  logic        vpenable;
  logic [31:0] vpaddr;
  logic        vpwrite;
  logic [31:0] vpwdata;
  logic [31:0] vprdata;
  modport master (output vpsel, vpenable, vpaddr, vpwrite, vpwdata, input vprdata);
  modport slave  (input vpsel, vpenable, vpaddr, vpwrite, vpwdata, output vprdata);
endinterface

// File: rtl/keymill_core.sv
// keymill_core: A/B generator with warm-up FSM and MSB-first 32-bit output collector
module keymill_core
  import keymill_pkg::*;
#(
  parameter int WARMUP = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_start,
  input  logic         i_full,
  input  logic [127:0] i_key,
  input  logic [127:0] i_iv,
  output logic         o_busy,
  output logic         o_load,
  output logic         o_push,
  output logic [31:0]  o_word
);
  localparam int CW = $clog2(WARMUP) + 1;
  state_t r_state, w_next;
  logic [127:0] r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_col;
  logic [4:0] r_bits;
  logic w_z, w_w, w_fa, w_fb, w_step, w_run;
  assign w_z    = r_a[Z_HI] ^ r_b[Z_HI] ^ (r_a[Z_AND] & r_b[Z_AND]);
  assign w_w    = (r_state == S_WARM) ? w_z : 1'b0;
  assign w_fa   = r_a[FA_T0] ^ r_a[FA_T1] ^ r_a[FA_T2] ^ r_a[FA_T3] ^ (r_a[FA_N0] & r_a[FA_N1]) ^ r_b[0];
  assign w_fb   = r_b[FB_T0] ^ r_b[FB_T1] ^ r_b[FB_T2] ^ r_b[FB_T3] ^ (r_b[FB_N0] & r_b[FB_N1]) ^ r_a[0];
  assign o_busy = r_state == S_WARM;
  assign o_word = {r_col[30:0], w_z};
  assign o_push = w_run && (r_bits == 5'd31);
  always_comb begin
    w_next = r_state;
    o_load = 1'b0;
    w_step = 1'b0;
    w_run  = 1'b0;
    if (i_clr) w_next = S_IDLE;
    else if (i_start && r_state != S_WARM) begin
      w_next = S_WARM;
      o_load = 1'b1;
    end else if (r_state == S_WARM) begin
      w_step = 1'b1;
      w_next = (r_cnt == CW'(WARMUP - 1)) ? S_RUN : S_WARM;
    end else if (r_state == S_RUN) begin
      w_step = !i_full;
      w_run  = !i_full;
    end
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  // A full FIFO simply withholds the step, so no generated bit is ever dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_col  <= '0;
      r_bits <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_col  <= '0;
      r_bits <= '0;
    end else if (o_load) begin
      r_a    <= i_key;
      r_b    <= i_iv;
      r_cnt  <= '0;
      r_col  <= '0;
      r_bits <= '0;
    end else if (w_step) begin
      r_a   <= {r_a[126:0], w_fa ^ w_w};
      r_b   <= {r_b[126:0], w_fb ^ w_w};
      r_cnt <= o_busy ? r_cnt + CW'(1) : r_cnt;
      if (w_run) begin
        r_col  <= o_word;
        r_bits <= r_bits + 5'd1;
      end
    end
  end
endmodule

// File: rtl/keymill_apb.sv
// keymill_apb: APB register front-end, keystream FIFO and read mux around keymill_core
module keymill_apb
  import keymill_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          WARMUP     = 256,
  parameter logic [31:0] ID_VALUE   = 32'h4B4D0001
) (
  input logic          vclk,
  input logic          vrst,
  keymill_apb_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  logic w_acc, w_wr, w_rd, w_ctrl, w_sw_reset, w_start, w_busy, w_load, w_push, w_pop, w_flush, w_full, w_empty;
  logic w_unused;
  logic [5:0] w_idx;
  logic [31:0] w_word, w_status, w_rdata, r_rdata;
  logic [127:0] r_key, r_iv;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [NW-1:0] r_count;
  assign w_acc      = bus.vpsel[0] & bus.vpenable;
  assign w_wr       = w_acc & bus.vpwrite;
  assign w_rd       = w_acc & ~bus.vpwrite;
  assign w_idx      = bus.vpaddr[7:2];
  assign w_unused   = ^{bus.vpsel[7:1], bus.vpaddr[31:8], bus.vpaddr[1:0]};
  assign w_ctrl     = w_wr && (w_idx == IDX_CTRL);
  assign w_sw_reset = w_ctrl & bus.vpwdata[CTRL_SWRST];
  assign w_start    = w_ctrl & bus.vpwdata[CTRL_START];
  assign w_full     = r_count == NW'(FIFO_DEPTH);
  assign w_empty    = r_count == '0;
  assign w_pop      = w_rd && (w_idx == IDX_STREAM) && !w_empty;
  assign w_flush    = w_sw_reset | w_load;
  assign w_status   = (32'(w_busy) << ST_BUSY) | (32'(w_empty) << ST_EMPTY);
  assign w_rdata    = (w_idx == IDX_CTRL)   ? w_status :
                      (w_idx == IDX_STREAM) ? (w_empty ? '0 : r_mem[r_rp]) :
                      (w_idx == IDX_ID)     ? ID_VALUE : '0;
  assign bus.vprdata = r_rdata;
  keymill_core #(.WARMUP(WARMUP)) u_core (
    .clk     (vclk),
    .rst     (vrst),
    .i_clr   (w_sw_reset),
    .i_start (w_start),
    .i_full  (w_full),
    .i_key   (r_key),
    .i_iv    (r_iv),
    .o_busy  (w_busy),
    .o_load  (w_load),
    .o_push  (w_push),
    .o_word  (w_word)
  );
  // Word index 1 holds the most significant 32 bits of KEY (5 for IV)
  always_ff @(posedge vclk) begin
    if (vrst) begin
      r_key <= '0;
      r_iv  <= '0;
    end else if (w_wr && !w_busy) begin
      for (int i = 0; i < 4; i++) begin
        if (w_idx == IDX_KEY0 + 6'(i)) r_key[127 - 32*i -: 32] <= bus.vpwdata;
        if (w_idx == IDX_IV0 + 6'(i)) r_iv[127 - 32*i -: 32] <= bus.vpwdata;
      end
    end
  end
  always_ff @(posedge vclk) if (w_push) r_mem[r_wp] <= w_word;
  always_ff @(posedge vclk) begin
    if (vrst || w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + AW'(w_push);
      r_rp    <= r_rp + AW'(w_pop);
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
    end
  end
  always_ff @(posedge vclk) begin
    if (vrst || w_sw_reset) r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata;
  end
endmodule

// File: tb/tb_keymill_apb.sv
// tb_keymill_apb: randomized APB traffic against a bit-level KEYMILL model, checked through a read scoreboard
module tb_keymill_apb;
  localparam int WARMUP = 256;
  localparam logic [5:0] CTRL = 6'h00, STREAM = 6'h01, KEY0 = 6'h01, IV0 = 6'h05, ID = 6'h21;
  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sb_t sb_q[$];
  sb_t mon_e;
  logic [31:0] ref_q[$];
  int ref_i, n_chk, n_fail;
  logic [127:0] key, iv;
  logic [5:0] u_idx;
  keymill_apb_if bus();
  keymill_apb dut (.vclk(clk), .vrst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: read %08h, model %08h", tag, got, exp);
    end
  endtask
  // Monitor: every accepted read transfer must match the oldest pending expectation
  always @(posedge clk) begin
    if (bus.vpsel[0] && bus.vpenable && !bus.vpwrite) begin
      #1;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: read %08h, model has no pending read", bus.vprdata);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.tag, bus.vprdata, mon_e.exp);
      end
    end
  end
  task automatic build_ref(input logic [127:0] k, input logic [127:0] v, input int n);
    logic [127:0] a, b;
    logic z, fa, fb;
    logic [31:0] wd;
    a = k;
    b = v;
    wd = '0;
    ref_q.delete();
    for (int s = 0; s < WARMUP + 32*n; s++) begin
      z  = a[127] ^ b[127] ^ (a[63] & b[63]);
      fa = a[127] ^ a[125] ^ a[100] ^ a[98] ^ (a[64] & a[32]) ^ b[0];
      fb = b[127] ^ b[126] ^ b[101] ^ b[99] ^ (b[70] & b[40]) ^ a[0];
      if (s < WARMUP) begin
        fa = fa ^ z;
        fb = fb ^ z;
      end else begin
        wd = {wd[30:0], z};
        if ((s - WARMUP) % 32 == 31) ref_q.push_back(wd);
      end
      a = {a[126:0], fa};
      b = {b[126:0], fb};
    end
    ref_i = 0;
  endtask
  task automatic drive(input logic wr, input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    bus.vpsel    = 8'($urandom) | 8'h01;
    bus.vpenable = 1'b1;
    bus.vpwrite  = wr;
    bus.vpaddr   = {24'($urandom), idx, 2'($urandom)};
    bus.vpwdata  = data;
  endtask
  task automatic wr_reg(input logic [5:0] idx, input logic [31:0] data);
    drive(1'b1, idx, data);
  endtask
  task automatic rd_reg(input logic [5:0] idx, input logic [31:0] exp, input string tag);
    sb_t e;
    drive(1'b0, idx, $urandom);
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask
  task automatic rd_stream(input string tag);
    rd_reg(STREAM, ref_q[ref_i], $sformatf("%s_w%0d", tag, ref_i));
    ref_i++;
  endtask
  // Idle cycles carry random non-transfers: either psel[0] low or penable low
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.vpsel    = 8'($urandom);
      bus.vpenable = bus.vpsel[0] ? 1'b0 : 1'($urandom);
      bus.vpwrite  = 1'($urandom);
      bus.vpaddr   = $urandom;
      bus.vpwdata  = $urandom;
    end
  endtask
  task automatic load_key_iv();
    for (int i = 0; i < 4; i++) wr_reg(KEY0 + 6'(i), key[127 - 32*i -: 32]);
    for (int i = 0; i < 4; i++) wr_reg(IV0 + 6'(i), iv[127 - 32*i -: 32]);
  endtask
  task automatic rd_unmapped();
    do u_idx = 6'($urandom_range(2, 63)); while (u_idx == ID);
    rd_reg(u_idx, 32'h0, $sformatf("unmapped_%02h", u_idx));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.vpsel = '0; bus.vpenable = 1'b0; bus.vpwrite = 1'b0; bus.vpaddr = '0; bus.vpwdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_prdata", bus.vprdata, 32'h0);
    rd_reg(ID, 32'h4B4D0001, "id");
    rd_reg(CTRL, 32'h40000000, "reset_status");
    rd_reg(STREAM, 32'h0, "reset_stream_empty");
    repeat (4) rd_unmapped();
    key = 128'h89ABCDEF_01234567_89ABCDEF_01234567;
    iv  = key;
    load_key_iv();
    build_ref(key, iv, 12);
    wr_reg(CTRL, 32'h1);
    for (int k = 1; k <= 300; k++)
      rd_reg(CTRL, (k <= WARMUP) ? 32'hC0000000 : (k <= WARMUP + 32) ? 32'h40000000 : 32'h0,
             $sformatf("status_k%0d", k));
    idle(120);
    repeat (3) rd_stream("first");
    idle(2);
    check("prdata_hold", bus.vprdata, ref_q[2]);
    wr_reg(CTRL, 32'h1);
    ref_i = 0;
    idle(400);
    repeat (3) rd_stream("restart");
    wr_reg(CTRL, 32'h3);
    idle(1);
    check("swrst_prdata", bus.vprdata, 32'h0);
    rd_reg(CTRL, 32'h40000000, "swrst_status");
    rd_reg(STREAM, 32'h0, "swrst_stream_empty");
    idle(300);
    rd_reg(CTRL, 32'h40000000, "swrst_beats_start");
    wr_reg(CTRL, 32'h1);
    idle(9);
    wr_reg(KEY0, 32'h0);
    idle(49);
    wr_reg(CTRL, 32'h1);
    idle(WARMUP - 61);
    rd_reg(CTRL, 32'hC0000000, "warm_last");
    rd_reg(CTRL, 32'h40000000, "run_first");
    idle(500);
    ref_i = 0;
    repeat (4) rd_stream("full");
    rd_reg(CTRL, 32'h40000000, "drained_status");
    idle(80);
    rd_reg(CTRL, 32'h0, "refilled_status");
    repeat (2) rd_stream("after_stall");
    rd_reg(CTRL, 32'h40000000, "drained2_status");
    repeat (3) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      iv  = {$urandom, $urandom, $urandom, $urandom};
      load_key_iv();
      build_ref(key, iv, 12);
      wr_reg(CTRL, 32'h1);
      idle(WARMUP + 128 + $urandom_range(1, 60));
      repeat (4) rd_stream("rnd_a");
      idle($urandom_range(130, 200));
      repeat (4) rd_stream("rnd_b");
      rd_unmapped();
    end
    idle(3);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keymill_apb.md
Name: keymill_apb

Overview:
- APB-slave keystream-generator coprocessor, KEYMILL-style: 128-bit key plus 128-bit IV, a warm-up phase, then a continuous 32-bit keystream delivered through a small output FIFO.
- Sits on the SoC APB bus. Software writes KEY, IV and CTRL, polls STATUS, then pops keystream words from STREAM_OUT.

Parameters:
- FIFO_DEPTH, 4: output word buffer depth (power of 2).
- WARMUP, 256: generator steps executed before the first output bit.
- ID_VALUE, 32'h4B4D0001: constant returned by the ID register.

Ports:
- vclk  in  1  clock, rising edge.
- vrst  in  1  reset; one clock, synchronous, active-high.
- vpsel  in  8  slave select; only vpsel[0] is used.
- vpenable  in  1  strobe.
- vpaddr  in  32  byte address; only vpaddr[7:2] (word index) is decoded.
- vpwrite  in  1  1 = write, 0 = read.
- vpwdata  in  32  write data.
- vprdata  out  32  read data, registered.

Behaviour:
- Access qualifier: acc = vpsel[0] & vpenable.
  - Every clock with acc high is one transfer; no wait states, no pready.
  - wr = acc & vpwrite; rd = acc & ~vpwrite.
- Write map (word index):
  - 0x00 CTRL: bit0 START, bit1 SW_RESET. Bits are self-clearing pulses, not stored.
  - 0x01..0x04: KEY[127:0], 0x01 = bits 127:96.
  - 0x05..0x08: IV[127:0], 0x05 = bits 127:96.
  - KEY and IV writes while BUSY=1 are ignored.
- Read map:
  - 0x00 STATUS = {BUSY, BUF_EMPTY, 30'b0}.
  - 0x01 STREAM_OUT: FIFO head; pops the FIFO if non-empty, else returns 0 with no pop.
  - 0x21 ID = ID_VALUE.
  - All other addresses read 0.
- vprdata is updated on the clock edge of a rd cycle and holds its value otherwise. Reset value 0.
  - Back-to-back reads of 0x01 on consecutive cycles pop consecutive words.
- Generator state:
  - A[127:0] and B[127:0].
  - Output bit z = A[127] ^ B[127] ^ (A[63] & B[63]).
  - fa = A[127]^A[125]^A[100]^A[98]^(A[64]&A[32])^B[0].
  - fb = B[127]^B[126]^B[101]^B[99]^(B[70]&B[40])^A[0].
  - Step: A <= {A[126:0], fa^w}; B <= {B[126:0], fb^w}. w = z during warm-up, else 0.
- FSM states IDLE, WARM, RUN.
  - IDLE: BUSY=0, generator frozen.
  - START in IDLE or RUN: A<=KEY, B<=IV, counter<=0, FIFO flushed, go to WARM.
  - START while in WARM is ignored.
  - WARM: BUSY=1; one step per clock; after WARMUP steps go to RUN.
  - RUN: BUSY=0. One step per clock while FIFO is not full; z is shifted MSB-first into a 32-bit collector. Each 32 bits form one word pushed to the FIFO. When the FIFO is full, stepping stalls with no bit loss.
- Timing: the first word is available WARMUP+32 clocks after the START edge.
- BUF_EMPTY = (FIFO count == 0).
- Simultaneous pop and push in one cycle: both take effect; count unchanged.
- SW_RESET, or vrst high:
  - Go to IDLE, flush FIFO, clear collector, vprdata<=0.
  - vrst also clears KEY and IV to 0. SW_RESET preserves KEY and IV.
  - SW_RESET has priority over START in the same write.
- Reset status: BUSY=0, BUF_EMPTY=1, i.e. STATUS = 32'h40000000.

Decomposition:
- Shared package keymill_pkg holds:
  - register word-index constants (CTRL, KEY0-3, IV0-3, STREAM_OUT, ID);
  - STATUS bit positions;
  - the FSM state enum;
  - the tap positions.
- One natural sub-module: keymill_core, containing A/B, the step logic, the FSM, the collector and the FIFO push. keymill_apb contains the decode, registers, FIFO and read mux.

Test Plan:
- After reset, read 0x21 -> 32'h4B4D0001. Read 0x00 -> 32'h40000000.
- Write KEY = 89ABCDEF,01234567,89ABCDEF,01234567 and IV the same, then CTRL = 1. STATUS reads 32'hC0000000 for 256 cycles, then 32'h00000000 by cycle 288.
- Pop 3 words via consecutive reads of 0x01. Repeat START with the same KEY/IV. The same 3 words appear in order, and they match a bit-level reference model of the z/fa/fb equations.
- Write CTRL = 2 mid-RUN -> STATUS = 32'h40000000. A read of 0x01 returns 0. KEY is retained, so a following START reproduces the same stream.
- Write KEY0 = 0 during WARM -> ignored: the stream equals the unmodified-key stream.
- Let the FIFO fill (no reads for 200 cycles), then pop 6 words. The first 4 match the model in order with no gap. Words 5 and 6 continue the sequence after the stall, and BUF_EMPTY toggles correctly.
